// File: rtl/switch_debounce_pkg.sv
// Shared constants and sizing helper for the switch conditioning block.
// Pure declarations; no logic, no latency, no flow control.
package switch_debounce_pkg;

    // 10 ms at 100 MHz for silicon; a short window keeps simulation fast.
    localparam int CNT_MAX_HW  = 1_000_000;
    localparam int CNT_MAX_SIM = 4;

    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, stability counter, output level flop and edge pulses.
// Latency SYNC_STAGES+CNT_MAX edges for a clean step; no backpressure, pulses are fire-and-forget.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_MAX     = CNT_MAX_HW
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int CW = cnt_width(CNT_MAX);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_sw;
    logic                   r_rise;
    logic                   r_fall;

    logic w_s;
    logic w_diff;
    logic w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = w_s ^ r_sw;
    // Any return to the accepted level clears the count, so bounces earn no partial credit.
    assign w_done = w_diff && (r_cnt == CW'(CNT_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sw   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_done & w_s;
            r_fall <= w_done & ~w_s;
            if (!w_diff || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_done) begin
                r_sw <= w_s;
            end
        end
    end

    assign o_sw     = r_sw;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_done;

endmodule

// File: rtl/switch_debounce.sv
// Conditions WIDTH raw switch levels into debounced levels plus per-bit rise/fall and a shared changed pulse.
// Latency SYNC_STAGES+CNT_MAX edges; no backpressure, all outputs are registered one-cycle pulses/levels.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_MAX     = CNT_MAX_HW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] w_accept;
    logic             r_changed;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_MAX     (CNT_MAX)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .i_sw     (sw_in[g]),
            .o_sw     (sw_out[g]),
            .o_rise   (rise[g]),
            .o_fall   (fall[g]),
            .o_accept (w_accept[g])
        );
    end

    // Registered from the per-bit accept strobes so it lines up with rise/fall, not a cycle behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_accept;
        end
    end

    assign changed = r_changed;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with the short simulation debounce window.
// Inputs driven 1 time unit after each rising edge; outputs sampled there too.
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    localparam int W = 4;
    localparam logic [7:0] LED_TBL = 8'b1010_0110;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .CNT_MAX     (CNT_MAX_SIM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic mux_led(input logic [W-1:0] v);
        return v[3] & LED_TBL[v[2:0]];
    endfunction

    initial begin
        int nfall, nrise, nlow, fall_at, rise_at, nchg, bad_tog;
        logic [W-1:0] exp_sw;
        logic exp_led [8];
        exp_led = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1: reset with all switches high
        rst   = 1'b1;
        sw_in = 4'hF;
        #2;
        chk("rst_async_sw", 32'(sw_out), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_sw",  32'(sw_out),  32'h0);
            chk("rst_pls", 32'({rise, fall, changed}), 32'h0);
        end

        // 2: release, 0101 held, accepted 6 edges later
        rst   = 1'b0;
        sw_in = 4'b0101;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t2_wait", 32'({sw_out, rise, changed}), 32'h0);
        end
        tick();
        chk("t2_sw",   32'(sw_out),  32'h5);
        chk("t2_rise", 32'(rise),    32'h5);
        chk("t2_fall", 32'(fall),    32'h0);
        chk("t2_chg",  32'(changed), 32'h1);
        tick();
        chk("t2_after", 32'({rise, changed}), 32'h0);
        chk("t2_hold",  32'(sw_out), 32'h5);

        // 3: bring bit0 low, bounce it, then settle high
        sw_in = 4'b0100;
        repeat (6) tick();
        chk("t3_low_sw",  32'(sw_out), 32'h4);
        chk("t3_low_fall", 32'(fall),  32'h1);
        bad_tog = 0;
        for (int k = 0; k < 4; k++) begin
            sw_in[0] = (k % 2 == 0);
            repeat (2) begin
                tick();
                if (sw_out != 4'b0100 || changed) bad_tog++;
            end
        end
        chk("t3_bounce", 32'(bad_tog), 32'h0);
        sw_in[0] = 1'b1;
        repeat (5) tick();
        chk("t3_pre", 32'(sw_out), 32'h4);
        tick();
        chk("t3_sw",   32'(sw_out), 32'h5);
        chk("t3_rise", 32'(rise),   32'h1);

        // 4: bit1 dips low for 5 cycles of input
        sw_in = 4'b0111;
        repeat (6) tick();
        chk("t4_up", 32'({sw_out, rise}), 32'h72);
        sw_in[1] = 1'b0;
        nfall = 0; nrise = 0; nlow = 0; fall_at = 0; rise_at = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (fall[1]) begin nfall++; fall_at = k; end
            if (rise[1]) begin nrise++; rise_at = k; end
            if (!sw_out[1]) nlow++;
            if (k == 5) sw_in[1] = 1'b1;
        end
        chk("t4_nfall",  32'(nfall),   32'd1);
        chk("t4_nrise",  32'(nrise),   32'd1);
        chk("t4_fallat", 32'(fall_at), 32'd6);
        chk("t4_riseat", 32'(rise_at), 32'd11);
        chk("t4_nlow",   32'(nlow),    32'd5);

        // 5: reset 3 cycles into a pending rise on bit3
        sw_in = 4'b1111;
        repeat (3) tick();
        chk("t5_pend", 32'(sw_out), 32'h7);
        rst = 1'b1;
        #1;
        chk("t5_async", 32'(sw_out), 32'h0);
        repeat (2) tick();
        chk("t5_held", 32'({sw_out, rise, fall, changed}), 32'h0);
        rst = 1'b0;
        repeat (5) tick();
        chk("t5_early", 32'(rise), 32'h0);
        tick();
        chk("t5_rise", 32'(rise),   32'hF);
        chk("t5_sw",   32'(sw_out), 32'hF);

        // 6: walk all x codes with EN=1
        for (int x = 0; x < 8; x++) begin
            sw_in  = {1'b1, 3'(x)};
            exp_sw = {1'b1, 3'(x)};
            nchg   = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (changed) nchg++;
            end
            chk($sformatf("t6_sw%0d", x),  32'(sw_out),          32'(exp_sw));
            chk($sformatf("t6_chg%0d", x), 32'(nchg),            32'd1);
            chk($sformatf("t6_led%0d", x), 32'(mux_led(sw_out)), 32'(exp_led[x]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
